seq_divider: RTL

- Sequential restoring shift-subtract unsigned divider. It is the inverse companion of the shift-add multiplier.
- Accepts dividend and divisor on a start strobe and iterates one quotient bit per two clocks.
- Presents quotient and remainder with a one-cycle done pulse.
- Sits beside the multiplier in the arithmetic unit and shares its start/busy style of control.

---
 rtl/divider_pkg.sv | 18 +
 rtl/divider_controller.sv | 84 ++++++++
 rtl/seq_divider.sv | 86 ++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the width helper for the iteration counter.
package divider_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    SUB   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // The counter must be able to hold WIDTH itself, not just WIDTH-1.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divider_controller.sv
// Control FSM for the divider: sequences LOAD, WIDTH SHIFT/SUB pairs and DONE,
// and owns the iteration counter.
module divider_controller
  import divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic divisor_zero,
  output logic ld,
  output logic shift,
  output logic sub_en,
  output logic done,
  output logic busy,
  output logic last
);

  localparam int CW = count_width(WIDTH);

  state_t         state;
  state_t         next_state;
  logic [CW-1:0]  count;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (ld) begin
      count <= CW'(WIDTH);
    end else if (sub_en) begin
      count <= count - CW'(1);
    end
  end

  assign last = (count == CW'(1));

  // Moore decode: every control output depends on the present state only.
  always_comb begin
    next_state = state;
    ld         = 1'b0;
    shift      = 1'b0;
    sub_en     = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD;
      end
      LOAD: begin
        ld         = 1'b1;
        busy       = 1'b1;
        next_state = divisor_zero ? DONE : SHIFT;
      end
      SHIFT: begin
        shift      = 1'b1;
        busy       = 1'b1;
        next_state = SUB;
      end
      SUB: begin
        sub_en     = 1'b1;
        busy       = 1'b1;
        next_state = last ? DONE : SHIFT;
      end
      DONE: begin
        done       = 1'b1;
        busy       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring shift-subtract unsigned divider: datapath registers
// plus the controller instance; one quotient bit per SHIFT/SUB pair.
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;

  logic             ld;
  logic             shift;
  logic             sub_en;
  logic             last;
  logic             r_ge_d;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  divider_controller #(.WIDTH(WIDTH)) u_ctrl (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .divisor_zero (divisor == '0),
    .ld           (ld),
    .shift        (shift),
    .sub_en       (sub_en),
    .done         (done),
    .busy         (busy),
    .last         (last)
  );

  // R is one bit wider than D so the shifted partial remainder never overflows.
  assign r_ge_d = (r_reg >= {1'b0, d_reg});
  assign r_next = r_ge_d ? (r_reg - {1'b0, d_reg}) : r_reg;
  assign q_next = {q_reg[WIDTH-1:1], r_ge_d};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (ld) begin
        d_reg       <= divisor;
        q_reg       <= dividend;
        r_reg       <= '0;
        div_by_zero <= (divisor == '0);
        // Divide by zero skips the iterations, so the result is published here.
        if (divisor == '0) begin
          quotient  <= '1;
          remainder <= dividend;
        end
      end
      if (shift) begin
        r_reg <= {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        q_reg <= {q_reg[WIDTH-2:0], 1'b0};
      end
      if (sub_en) begin
        r_reg <= r_next;
        q_reg <= q_next;
        // Outputs only ever see the final values, on the transition into DONE.
        if (last) begin
          quotient  <= q_next;
          remainder <= r_next[WIDTH-1:0];
        end
      end
    end
  end

endmodule
